// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, a buffered secondary requester drains into idle cycles.
// Optional same-cycle bypass of an empty FIFO is enabled by defining WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RegWriteW,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     sec_valid,
    output logic                     sec_ready,
    input  logic [4:0]               sec_addr,
    input  logic [31:0]              sec_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    input  logic [4:0]               hz_addr,
    output logic                     hz_pending,
    output logic                     force_bubble,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             bubble_q, bubble_d;

    logic pipe_wr, empty, full, bypass, pop, push, hit;

    assign pipe_wr = RegWriteW && (wb_addr != 5'd0);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));

`ifdef WB_ARB_BYPASS_EN
    assign bypass = empty && !pipe_wr && sec_valid && (sec_addr != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    assign pop       = !pipe_wr && !empty;
    assign sec_ready = !full;
    assign push      = sec_valid && !full && (sec_addr != 5'd0) && !bypass;

    assign fifo_count   = count_q;
    assign force_bubble = bubble_q;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_wr) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (!empty) begin
            rf_we    = 1'b1;
            rf_waddr = addr_q[rd_ptr_q];
            rf_wdata = data_q[rd_ptr_q];
        end else if (bypass) begin
            rf_we    = 1'b1;
            rf_waddr = sec_addr;
            rf_wdata = sec_data;
        end
    end

    // Hazard lookup sees only registered entries, never this cycle's push.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == hz_addr)) hit = 1'b1;
        end
        hz_pending = (hz_addr != 5'd0) && hit;
    end

    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        starve_d = '0;
        if (!empty && !pop)
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;

        // A pop releases the bubble; otherwise it latches once the counter has saturated.
        bubble_d = bubble_q;
        if (pop)
            bubble_d = 1'b0;
        else if (starve_q == SW'(STARVE_LIMIT))
            bubble_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            bubble_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            bubble_q <= bubble_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr_q] <= sec_addr;
            data_q[wr_ptr_q] <= sec_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model (honours WB_ARB_BYPASS_EN).
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic        CLK, RST;
    logic        RegWriteW, sec_valid, sec_ready;
    logic [4:0]  wb_addr, sec_addr, rf_waddr, hz_addr;
    logic [31:0] wb_data, sec_data, rf_wdata;
    logic        rf_we, hz_pending, force_bubble;
    logic [2:0]  fifo_count;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .RegWriteW(RegWriteW), .wb_addr(wb_addr), .wb_data(wb_data),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .hz_addr(hz_addr), .hz_pending(hz_pending),
        .force_bubble(force_bubble), .fifo_count(fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   starve;
    bit   bubble;
    int   vectors;
    int   miscompares;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares every output against the model, then advances the model across one clock edge.
    task automatic checkOutput();
        bit          pw, byp, popped, pushed, hzHit;
        logic        expWe;
        logic [4:0]  expA;
        logic [31:0] expD;
        ent_t        e;

        pw  = RegWriteW && (wb_addr != 0);
        byp = BYPASS && (q.size() == 0) && !pw && sec_valid && (sec_addr != 0);
        expWe = 1'b0; expA = '0; expD = '0;
        if (pw) begin
            expWe = 1'b1; expA = wb_addr; expD = wb_data;
        end else if (q.size() > 0) begin
            expWe = 1'b1; expA = q[0].a; expD = q[0].d;
        end else if (byp) begin
            expWe = 1'b1; expA = sec_addr; expD = sec_data;
        end
        hzHit = 1'b0;
        foreach (q[i]) if (q[i].a == hz_addr) hzHit = 1'b1;

        check("rf_we", rf_we, expWe);
        check("rf_waddr", rf_waddr, expA);
        check("rf_wdata", rf_wdata, expD);
        check("sec_ready", sec_ready, q.size() < DEPTH);
        check("fifo_count", fifo_count, q.size());
        check("hz_pending", hz_pending, (hz_addr != 0) && hzHit);
        check("force_bubble", force_bubble, bubble);

        popped = !pw && (q.size() > 0);
        pushed = sec_valid && (q.size() < DEPTH) && (sec_addr != 0) && !byp;
        if (popped) bubble = 1'b0;
        else if (starve == LIM) bubble = 1'b1;
        if (q.size() > 0 && !popped) starve = (starve < LIM) ? starve + 1 : LIM;
        else starve = 0;
        if (popped) void'(q.pop_front());
        if (pushed) begin
            e.a = sec_addr; e.d = sec_data;
            q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                                 input bit sv, input logic [4:0] sa, input logic [31:0] sd,
                                 input logic [4:0] ha);
        RegWriteW = we; wb_addr = wa; wb_data = wd;
        sec_valid = sv; sec_addr = sa; sec_data = sd;
        hz_addr = ha;
        #1;
        checkOutput();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int pct;
        vectors = 0; miscompares = 0;
        starve = 0; bubble = 0;
        RST = 1'b1;
        RegWriteW = 0; wb_addr = 0; wb_data = 0;
        sec_valid = 0; sec_addr = 0; sec_data = 0; hz_addr = 5'd7;

        // Reset then idle
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rf_we", rf_we, 0);
        check("rst_sec_ready", sec_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_bubble", force_bubble, 0);
        check("rst_hz", hz_pending, 0);
        RST = 1'b0;
        idle(2);

        // Pipeline priority; buffered r7 visible to hazard query next cycle, then drains
        applyStimulus(1, 5, 32'hAAAA0000, 1, 7, 32'h1234, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 7);

        // Full FIFO with a held 5th request
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 5'(i + 1), 32'h100 + i, 1, 5'(10 + i), 32'hB000 + i, 5'(10 + i));
        check("full_count", fifo_count, 4);
        check("full_ready", sec_ready, 0);
        applyStimulus(1, 5, 32'h5, 1, 20, 32'hC0DE, 20);
        applyStimulus(0, 0, 0, 1, 20, 32'hC0DE, 20);
        applyStimulus(0, 0, 0, 1, 20, 32'hC0DE, 20);
        applyStimulus(0, 0, 0, 0, 0, 0, 20);
        idle(5);

        // Starvation with continuous pipeline writes, then drain
        applyStimulus(1, 1, 32'h1, 1, 3, 32'h3333, 3);
        for (int i = 0; i < 12; i++)
            applyStimulus(1, 5'((i % 31) + 1), 32'h200 + i, 0, 0, 0, 3);
        check("starve_bubble", force_bubble, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3);
        check("starve_clear", force_bubble, 0);
        idle(2);

        // $0 filtering
        applyStimulus(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Bypass (or one-cycle buffered latency without it)
        applyStimulus(0, 0, 0, 1, 9, 32'h55, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 9);
        idle(1);

        // Reset mid-operation with 3 buffered entries
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'(i + 2), 32'h300 + i, 1, 5'(15 + i), 32'hD00 + i, 15);
        RegWriteW = 0; sec_valid = 0; hz_addr = 5'd15;
        #2 RST = 1'b1;
        #1;
        check("midrst_count", fifo_count, 0);
        check("midrst_we", rf_we, 0);
        check("midrst_hz", hz_pending, 0);
        q.delete(); starve = 0; bubble = 0;
        @(posedge CLK); #1;
        check("midrst_we2", rf_we, 0);
        @(negedge CLK);
        RST = 1'b0;
        idle(3);

        // Random traffic in phases of varying pipeline pressure
        for (int i = 0; i < 600; i++) begin
            logic [4:0] ha;
            pct = ((i / 100) % 2 == 0) ? 90 : 40;
            if (bubble) pct = 10;
            ha = 5'($urandom_range(0, 31));
            if (q.size() > 0 && $urandom_range(0, 1) == 1) ha = q[$urandom_range(0, q.size() - 1)].a;
            applyStimulus($urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom,
                          $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, ha);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
